rom_note_sequencer: RTL
=======================

// Module: rom_note_sequencer
// PURPOSE
//  Avalon-MM read master that walks the 512x32 song/program ROM word by word.
//  Each word is decoded into a note: a tone half-period and a duration.
//  Drives the downstream tone generator (tone_period/tone_en) for that duration.
//  Sits directly downstream of the on-chip ROM; the Nios II starts and stops it.
// PARAMETERS
//  ADDR_W    9      ROM word-address width (512 words)
//  PERIOD_W  20     tone half-period field width, in clk cycles
//  DUR_W     10     note duration field width, in ticks
//  TICK_DIV  50000  clk cycles per duration tick (1 ms at 50 MHz); must be >= 2
// PORTS
//  clk             in   1        system clock
//  reset           in   1        asynchronous, active-high reset
//  start           in   1        pulse: begin playback at start_addr (ignored while busy)
//  stop            in   1        pulse: abort playback
//  start_addr      in   ADDR_W   first word address, sampled on accepted start
//  rom_address     out  ADDR_W   ROM word address
//  rom_chipselect  out  1        ROM read strobe
//  rom_clken       out  1        ROM clock enable, tied 1
//  rom_readdata    in   32       ROM data; fixed read latency 1
//  tone_period     out  PERIOD_W half-period of current note; 0 = rest
//  tone_en         out  1        high while a note is sounding (PLAY, period != 0)
//  busy            out  1        high in any state except IDLE
//  done            out  1        one-cycle pulse when an END word is reached
// BEHAVIOUR
//  Word format: [31] END, [30] LOOP, [29:20] duration (DUR_W), [19:0] period (PERIOD_W).
//  Reset: state IDLE; rom_address=0, rom_chipselect=0, tone_period=0, tone_en=0,
//   busy=0, done=0, tick counter=0, duration counter=0, loop base=0.
//  FSM states:
//   IDLE  -> FETCH on start. Latch start_addr into rom_address and the loop base.
//   FETCH -> WAIT. rom_chipselect=1 for exactly this cycle.
//   WAIT  -> decode rom_readdata in this cycle. No rom_chipselect.
//    - END=1: go to IDLE, pulse done, tone_en=0. END has priority over LOOP.
//    - LOOP=1: rom_address <= loop base, go to FETCH. Tone is unchanged.
//    - duration=0: address+1, go to FETCH. Note is skipped; tone is unchanged.
//    - otherwise: load tone_period and duration, clear tick counter, go to PLAY.
//   PLAY  -> tone_en=(tone_period!=0). Tick counter counts 0..TICK_DIV-1.
//    - Each wrap decrements the duration counter.
//    - At the last wrap: address+1, go to FETCH.
//    - A note of duration d holds tone_en for exactly d*TICK_DIV cycles.
//  Note-to-note gap: 2 cycles (FETCH, WAIT), during which tone_en=0.
//  Address arithmetic is modulo 2^ADDR_W: 511+1 wraps to 0 with no error.
//  stop in any non-IDLE state:
//   - next state IDLE; tone_en=0 and tone_period=0 on the next edge.
//   - done is not pulsed.
//   - stop and start in the same cycle: stop wins.
//  start while busy: ignored (no restart, no start_addr sample).
//  start and stop in the same cycle while IDLE: stay IDLE.
//  Reset mid-operation: immediate return to reset values; no ROM read is left pending.
//  rom_clken is constant 1. This block never writes the ROM.
// STRUCTURE
//  Shared package, note_seq_pkg:
//   - field positions END_BIT=31, LOOP_BIT=30, DUR_LSB=20, PERIOD_LSB=0
//   - FSM state encoding {IDLE, FETCH, WAIT, PLAY}
//  One sub-module, note_tick_gen:
//   - free-running divider with synchronous clear; one-cycle tick every TICK_DIV cycles
//   - cleared on note load.
//  FSM, address register and duration counter live in the top module.
// TESTING
//  Run the bench with TICK_DIV=4 and a ROM model with latency 1.
//  T1 ROM[0]={dur=3,per=100}, ROM[1]=END; start@0
//   -> rom_chipselect pulses at addr 0 and then addr 1
//   -> tone_period=100 with tone_en high for 12 cycles
//   -> done pulses once; busy falls the cycle after WAIT on addr 1.
//  T2 ROM[5]={dur=1,per=0}, ROM[6]={dur=2,per=7}, ROM[7]=END; start@5
//   -> tone_en low for the rest note; tone_en high for 8 cycles with period 7.
//  T3 ROM[511]={dur=1,per=9}, ROM[0]=END; start@511
//   -> second fetch is at address 0; done pulses.
//  T4 ROM[2]={dur=1,per=3}, ROM[3]=LOOP|END=0; start@2; stop after 30 cycles
//   -> repeated fetches alternate between addresses 2 and 3
//   -> after stop: IDLE, tone_en=0, no done pulse.
//  T5 assert reset during PLAY; separately, pulse start while busy
//   -> reset: all outputs return to reset values asynchronously
//   -> start while busy: rom_address sequence unchanged.

Source files
------------

// File: rtl/note_seq_pkg.sv
// Shared definitions for the ROM note sequencer: ROM word field positions
// and the playback FSM state encoding.
package note_seq_pkg;

    localparam int END_BIT    = 31;
    localparam int LOOP_BIT   = 30;
    localparam int DUR_LSB    = 20;
    localparam int PERIOD_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        PLAY  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/rom_note_sequencer_if.sv
// Avalon-MM read-only port between the note sequencer (master) and the
// song ROM (slave); ROM read latency is one clock.
interface rom_note_sequencer_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] rom_address;
    logic              rom_chipselect;
    logic              rom_clken;
    logic [31:0]       rom_readdata;

    modport master (
        output rom_address,
        output rom_chipselect,
        output rom_clken,
        input  rom_readdata
    );

    modport slave (
        input  rom_address,
        input  rom_chipselect,
        input  rom_clken,
        output rom_readdata
    );
endinterface

// File: rtl/note_tick_gen.sv
// Free-running duration-tick divider: one-cycle tick every TICK_DIV clocks,
// restarted from zero by a synchronous clear when a new note is loaded.
module note_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rom_note_sequencer.sv
// Walks the song ROM word by word, decoding each word into a tone half-period
// and a duration, and drives the tone generator for that many ticks.
module rom_note_sequencer
    import note_seq_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int PERIOD_W = 20,
    parameter int DUR_W    = 10,
    parameter int TICK_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   start_addr,
    rom_note_sequencer_if.master rom,
    output logic [PERIOD_W-1:0] tone_period,
    output logic                tone_en,
    output logic                busy,
    output logic                done
);
    seq_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                done_q, done_d;

    logic                tick;
    logic                tick_clr;

    logic                word_end;
    logic                word_loop;
    logic [DUR_W-1:0]    word_dur;
    logic [PERIOD_W-1:0] word_period;

    assign word_end    = rom.rom_readdata[END_BIT];
    assign word_loop   = rom.rom_readdata[LOOP_BIT];
    assign word_dur    = rom.rom_readdata[DUR_LSB +: DUR_W];
    assign word_period = rom.rom_readdata[PERIOD_LSB +: PERIOD_W];

    note_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        base_d   = base_q;
        period_d = period_q;
        dur_d    = dur_q;
        done_d   = 1'b0;
        tick_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    addr_d  = start_addr;
                    base_d  = start_addr;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // END outranks LOOP; zero-duration words are skipped silently
                if (word_end) begin
                    period_d = '0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (word_loop) begin
                    addr_d  = base_q;
                    state_d = FETCH;
                end else if (word_dur == '0) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = FETCH;
                end else begin
                    period_d = word_period;
                    dur_d    = word_dur;
                    tick_clr = 1'b1;
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (dur_q == DUR_W'(1)) begin
                        dur_d   = '0;
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                    end else begin
                        dur_d = dur_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort outranks everything else, including a same-cycle start or END
        if (stop && (state_q != IDLE)) begin
            state_d  = IDLE;
            period_d = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            base_q   <= '0;
            period_q <= '0;
            dur_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            period_q <= period_d;
            dur_q    <= dur_d;
            done_q   <= done_d;
        end
    end

    assign rom.rom_address    = addr_q;
    assign rom.rom_chipselect = (state_q == FETCH);
    assign rom.rom_clken      = 1'b1;

    assign tone_period = period_q;
    assign tone_en     = (state_q == PLAY) && (period_q != '0);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
endmodule
